alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Issuer/collector at the control-path end of the ALU operation interface.
- Accepts one operation request at a time over a valid/ready handshake and drives the ALU select/operand lines for exactly one clock.
- Waits out the ALU's registered latency, captures the 64-bit {HI,LO} result into local HI/LO registers, and returns it over a response valid/ready handshake.

Parameters:
- DATA_W, 32, operand and LO/HI width; the ALU result bus is 2*DATA_W.
- WAIT_CYCLES, 1, clocks from the issue cycle until alu_c is valid; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- clr  input  1  synchronous active-low reset; sampled on the rising edge of clk, clears state when 0.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  4  ALU opcode.
- req_a  input  DATA_W  operand A.
- req_b  input  DATA_W  operand B.
- alu_select  output  4  ALU operation select.
- alu_a  output  DATA_W  ALU A operand.
- alu_y  output  DATA_W  ALU Y operand (first operand for AND/SUB/NEG/shifts); always equals alu_a.
- alu_b  output  DATA_W  ALU B operand.
- alu_c  input  2*DATA_W  ALU result {HI,LO}.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_lo  output  DATA_W  LO register.
- rsp_hi  output  DATA_W  HI register.
- rsp_err  output  1  request was rejected (unsupported op, or div-by-zero trap).

Behaviour:
- Supported opcodes: 0001, 0010, 0011 (mul), 0101 (div/mod), 0110, 0111, 1000, 1010, 1100, 1101, 1110, 1111.
- Unsupported opcodes: 0000, 0100, 1001, 1011.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op/a/b.
  - Supported op -> ISSUE.
  - Unsupported op -> RESP with rsp_err=1, LO/HI unchanged, ALU never driven.
- ISSUE: exactly one cycle.
  - alu_select=latched op; alu_a=alu_y=A; alu_b=B.
  - Next state: WAIT if WAIT_CYCLES>1, else CAPTURE.
- WAIT:
  - alu_select=0000 (ALU holds its result); operands held.
  - Down-counter runs WAIT_CYCLES-1 cycles, then -> CAPTURE.
- CAPTURE: one cycle, alu_select=0000.
  - lo_q <= alu_c[DATA_W-1:0].
  - hi_q <= alu_c[2*DATA_W-1:DATA_W] only for ops 0011 and 0101; otherwise hi_q retains its value.
  - rsp_err <= 0; -> RESP.
- RESP:
  - rsp_valid=1; rsp_lo/rsp_hi/rsp_err stable until rsp_ready=1.
  - Handshake completes -> IDLE.
  - req_ready=0 in every state except IDLE, so only one op is in flight and there is no overlap of response and new request.
- Latency (WAIT_CYCLES=1): accept at cycle 0, select driven in cycle 1, capture in cycle 2, rsp_valid in cycle 3. In general, rsp_valid is asserted in cycle 2+WAIT_CYCLES.
- alu_select is never held across two consecutive cycles. Re-executing div would corrupt the result, because the ALU's LO uses its own HI.
- rsp_lo/rsp_hi always reflect lo_q/hi_q, including while rsp_valid=0.
- Reset (clr=0 at a clock edge, any state, including mid-operation):
  - state=IDLE; alu_select=0000; alu_a/alu_y/alu_b=0.
  - lo_q=hi_q=0; rsp_valid=0; rsp_err=0; counter=0.
  - req_ready=0 in the reset cycle, 1 in the first cycle after clr returns to 1.
  - An operation in flight is dropped with no response.

Optional Feature:
- Macro DIV_ZERO_TRAP_EN.
- Defined: a request with op 0101 and req_b==0 is not issued. It goes IDLE -> RESP with rsp_err=1, lo_q/hi_q unchanged, and alu_select stays 0000.
- Not defined: divide-by-zero is issued like any other op, and whatever alu_c returns is captured with rsp_err=0.

Test Plan:
- Reset then op 0011, A=0x0001_0000, B=0x0001_0000 -> rsp_valid in cycle 3 after accept, rsp_hi=0x0000_0001, rsp_lo=0x0000_0000, rsp_err=0; alu_select=0011 for exactly one cycle.
- Op 0101, A=17, B=5, then op 0111, A=0xF0, B=0x0F -> first response hi=2, lo=3; second response lo=0xFF, hi still 2.
- Op 1001 (unsupported) -> rsp_valid next cycle after accept, rsp_err=1, LO/HI unchanged, alu_select never leaves 0000.
- Response backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready stays 0 and outputs are stable; rsp_ready=1 -> IDLE, the new request is accepted the following cycle.
- clr=0 asserted in the WAIT state (WAIT_CYCLES=3) -> next cycle all outputs are at reset values; no response is ever produced for the dropped op.
- Op 0101, B=0: with DIV_ZERO_TRAP_EN -> rsp_err=1, no ALU issue; without it -> alu_select=0101 issued once, rsp_err=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op per request, waits out ALU latency, captures {HI,LO}, returns response; define DIV_ZERO_TRAP_EN to reject div-by-zero
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  output logic [3:0]            alu_select,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_y,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [2*DATA_W-1:0]   alu_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_lo,
  output logic [DATA_W-1:0]     rsp_hi,
  output logic                  rsp_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;
  localparam int CW = WAIT_CYCLES > 2 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES > 1 ? WAIT_CYCLES - 2 : 0);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] op_q;
  logic [DATA_W-1:0] a_q, b_q, lo_q, hi_q;
  logic err_q, accept, supported, trap, issue_ok;
  assign accept = req_valid && req_ready;
  assign supported = !(req_op inside {4'h0, 4'h4, 4'h9, 4'hB});
`ifdef DIV_ZERO_TRAP_EN
  assign trap = req_op == 4'h5 && req_b == '0;
`else
  assign trap = 1'b0;
`endif
  assign issue_ok = supported && !trap;
  assign alu_a = a_q;
  assign alu_y = a_q;
  assign alu_b = b_q;
  assign rsp_lo = lo_q;
  assign rsp_hi = hi_q;
  assign rsp_err = err_q;
  // state register; a low clr drops any op in flight
  always_ff @(posedge clk) begin
    state <= !clr ? IDLE : state_n;
  end
  // next state and handshake/select outputs; select is driven only in the single ISSUE cycle
  always_comb begin
    state_n = state;
    req_ready = state == IDLE && clr;
    rsp_valid = state == RESP;
    alu_select = state == ISSUE ? op_q : 4'h0;
    case (state)
      IDLE:    state_n = accept ? (issue_ok ? ISSUE : RESP) : IDLE;
      ISSUE:   state_n = WAIT_CYCLES > 1 ? WAIT : CAPTURE;
      WAIT:    state_n = cnt == '0 ? CAPTURE : WAIT;
      CAPTURE: state_n = RESP;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // request latch, wait counter and HI/LO capture; HI only updates for mul and div
  always_ff @(posedge clk) begin
    if (!clr) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        a_q <= req_a;
        b_q <= req_b;
        err_q <= !issue_ok;
      end
      if (state == ISSUE) cnt <= CNT_INIT;
      else if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (state == CAPTURE) begin
        lo_q <= alu_c[DATA_W-1:0];
        if (op_q == 4'h3 || op_q == 4'h5) hi_q <= alu_c[2*DATA_W-1:DATA_W];
        err_q <= 1'b0;
      end
    end
  end
endmodule
